ras_circ: RTL and testbench
===========================

# ras_circ

Parametrised, clocked return-address stack for the fetch-stage branch predictor. It replaces the level-sensitive 32-entry RAS with a synchronous circular buffer of configurable depth and address width. Pushes on calls, pops on returns and supports a combined pop+push for the same cycle. It exports a pointer/count checkpoint so the back end can restore the stack after a misprediction flush. It sits between fetch-stage call/return decode and the next-PC mux.

## Interface
Parameters:
- XLEN, 32, return-address width in bits.
- DEPTH, 16, number of entries; power of two, 2..64.
- PTR_W, derived localparam = log2(DEPTH); not overridable.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  reset, synchronous, active-high.
- push_i  in  1  call seen; push push_addr_i.
- pop_i  in  1  return seen; pop top.
- push_addr_i  in  XLEN  return address to push (PC of call + 4).
- top_addr_o  out  XLEN  predicted return target = current top entry; all-ones when empty.
- top_valid_o  out  1  count_o != 0.
- count_o  out  PTR_W+1  valid entries, 0..DEPTH.
- ckpt_ptr_o  out  PTR_W  current write pointer, sampled by the back end per branch.
- ckpt_cnt_o  out  PTR_W+1  equals count_o; sampled together with ckpt_ptr_o.
- restore_i  in  1  misprediction recovery strobe.
- restore_ptr_i  in  PTR_W  pointer to reload.
- restore_cnt_i  in  PTR_W+1  count to reload; values > DEPTH are clamped to DEPTH.
- overflow_o  out  1  one-cycle pulse: a push overwrote the oldest entry.
- underflow_o  out  1  one-cycle pulse: a pop hit an empty stack.

## Operation
- State: array mem[DEPTH] of XLEN, with no reset. Write pointer wp (next free slot, modulo DEPTH). Saturating counter cnt.
- Top entry is mem[wp-1], modulo DEPTH. top_addr_o = (cnt==0) ? all-ones : mem[wp-1].
- Per-edge priority is reset > restore_i > push/pop.
- reset: wp=0, cnt=0, overflow_o=0, underflow_o=0. Entries are unchanged but unreachable.
- restore_i: wp=restore_ptr_i, cnt=min(restore_cnt_i, DEPTH). push_i and pop_i are ignored. No flag pulses.
- Push only: mem[wp]=push_addr_i, wp=wp+1 (wraps DEPTH-1 -> 0).
  - If cnt<DEPTH: cnt=cnt+1.
  - If cnt==DEPTH: cnt stays DEPTH, the oldest entry is silently overwritten, and overflow_o=1 for one cycle.
- Pop only:
  - If cnt>0: wp=wp-1 (wraps 0 -> DEPTH-1), cnt=cnt-1.
  - If cnt==0: no state change, underflow_o=1 for one cycle.
- Push and pop together (return-then-call in one fetch group):
  - If cnt>0: replace the top, mem[wp-1]=push_addr_i; wp and cnt unchanged; no flags.
  - If cnt==0: behave as push only, with no underflow.
- Neither push nor pop: hold.
- Restored entries are not repaired. Entries overwritten after the checkpoint stay lost; this is accepted predictor inaccuracy, not an error.

## Timing
- All state updates on the rising clk edge. Outputs are combinational from registered state only; there is no input-to-output combinational path.
- Latency: a push at edge N is visible on top_addr_o immediately after edge N. Back-to-back push/pop every cycle is supported; throughput is 1 op per cycle.
- overflow_o and underflow_o are registered and valid for exactly the cycle after the offending edge.
- Reset values: top_addr_o=all-ones, top_valid_o=0, count_o=0, ckpt_ptr_o=0, ckpt_cnt_o=0, overflow_o=0, underflow_o=0.
- Reset asserted mid-sequence wins over any simultaneous push, pop or restore.

## Test plan
- Reset, then push 0x100, 0x200, 0x300 (DEPTH=4) -> top_addr_o 0x300, count_o 3. Three pops -> tops 0x200, 0x100, then all-ones with top_valid_o=0.
- DEPTH=4: push 0x10..0x50 -> fifth push gives overflow_o pulse, count_o 4. Pops return 0x50, 0x40, 0x30, 0x20. Fifth pop gives underflow_o pulse and count_o stays 0.
- Stack holding 0xA0, 0xB0: push+pop with 0xC0 -> top 0xC0, count_o 2. Next pop -> top 0xA0. Push+pop on an empty stack with 0xD0 -> top 0xD0, count_o 1, no flags.
- Checkpoint after pushing 0x1000, 0x2000 (ckpt_ptr 2, cnt 2). Push 0x3000, pop, pop. Then restore_i with ptr 2, cnt 2 -> top 0x2000, count_o 2. Assert push_i in the same cycle as restore_i -> push ignored.
- restore_cnt_i=7 with DEPTH=4 -> count_o 4. Wrap check: push 6 values into DEPTH=4 -> ckpt_ptr_o 2, top is the 6th value.
- Reset asserted together with push_i on a stack holding 3 entries -> count_o 0, top_addr_o all-ones, no flag pulses the following cycle.

Source files
------------

// File: rtl/ras_circ.sv
// Clocked return-address stack kept as a circular buffer: push on call, pop on
// return, replace-top on pop+push, with a pointer/count checkpoint for flush recovery.
module ras_circ #(
  parameter int XLEN = 32,
  parameter int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [XLEN-1:0]  push_addr_i,
  output logic [XLEN-1:0]  top_addr_o,
  output logic             top_valid_o,
  output logic [PTR_W:0]   count_o,
  output logic [PTR_W-1:0] ckpt_ptr_o,
  output logic [PTR_W:0]   ckpt_cnt_o,
  input  logic             restore_i,
  input  logic [PTR_W-1:0] restore_ptr_i,
  input  logic [PTR_W:0]   restore_cnt_i,
  output logic             overflow_o,
  output logic             underflow_o
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [XLEN-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wp_reg;
  logic [PTR_W:0]   cnt_reg;
  logic             overflow_reg;
  logic             underflow_reg;

  logic [PTR_W-1:0] top_idx;
  logic             empty;
  logic             full;
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;
  logic [PTR_W:0]   restore_cnt_clamped;

  // Pointer arithmetic wraps for free because DEPTH is a power of two.
  assign top_idx = wp_reg - 1'b1;
  assign empty   = (cnt_reg == '0);
  assign full    = (cnt_reg == FULL_CNT);
  assign restore_cnt_clamped = (restore_cnt_i > FULL_CNT) ? FULL_CNT : restore_cnt_i;

  always_comb begin
    wr_en  = 1'b0;
    wr_idx = wp_reg;
    if (!reset && !restore_i) begin
      if (push_i && pop_i && !empty) begin
        wr_en  = 1'b1;
        wr_idx = top_idx;
      end else if (push_i) begin
        wr_en  = 1'b1;
        wr_idx = wp_reg;
      end
    end
  end

  // Entry storage carries no reset; stale entries are unreachable via cnt.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= push_addr_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp_reg        <= '0;
      cnt_reg       <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
      if (restore_i) begin
        wp_reg  <= restore_ptr_i;
        cnt_reg <= restore_cnt_clamped;
      end else if (push_i && pop_i && !empty) begin
        // Return-then-call replaces the top in place.
        wp_reg  <= wp_reg;
      end else if (push_i) begin
        wp_reg <= wp_reg + 1'b1;
        if (full) begin
          overflow_reg <= 1'b1;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end else if (pop_i) begin
        if (empty) begin
          underflow_reg <= 1'b1;
        end else begin
          wp_reg  <= top_idx;
          cnt_reg <= cnt_reg - 1'b1;
        end
      end
    end
  end

  assign top_addr_o  = empty ? '1 : mem[top_idx];
  assign top_valid_o = !empty;
  assign count_o     = cnt_reg;
  assign ckpt_ptr_o  = wp_reg;
  assign ckpt_cnt_o  = cnt_reg;
  assign overflow_o  = overflow_reg;
  assign underflow_o = underflow_reg;

endmodule

// File: tb/tb_ras_circ.sv
// Directed-vector bench for ras_circ at DEPTH=4: one table row per clock edge,
// followed by a short hand-written latency / no-combinational-path sequence.
module tb_ras_circ;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;
  localparam logic [31:0] FF = 32'hFFFF_FFFF;

  logic             clk;
  logic             reset;
  logic             push_i;
  logic             pop_i;
  logic [XLEN-1:0]  push_addr_i;
  logic [XLEN-1:0]  top_addr_o;
  logic             top_valid_o;
  logic [PTR_W:0]   count_o;
  logic [PTR_W-1:0] ckpt_ptr_o;
  logic [PTR_W:0]   ckpt_cnt_o;
  logic             restore_i;
  logic [PTR_W-1:0] restore_ptr_i;
  logic [PTR_W:0]   restore_cnt_i;
  logic             overflow_o;
  logic             underflow_o;

  int total = 0;
  int bad   = 0;

  ras_circ #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .push_i        (push_i),
    .pop_i         (pop_i),
    .push_addr_i   (push_addr_i),
    .top_addr_o    (top_addr_o),
    .top_valid_o   (top_valid_o),
    .count_o       (count_o),
    .ckpt_ptr_o    (ckpt_ptr_o),
    .ckpt_cnt_o    (ckpt_cnt_o),
    .restore_i     (restore_i),
    .restore_ptr_i (restore_ptr_i),
    .restore_cnt_i (restore_cnt_i),
    .overflow_o    (overflow_o),
    .underflow_o   (underflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        push;
    logic        pop;
    logic        rest;
    logic [31:0] addr;
    logic [1:0]  rptr;
    logic [2:0]  rcnt;
    logic [31:0] etop;
    logic [2:0]  ecnt;
    logic [1:0]  eptr;
    logic        eovf;
    logic        eudf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic push, logic pop, logic rest,
                              logic [31:0] addr, logic [1:0] rptr, logic [2:0] rcnt,
                              logic [31:0] etop, logic [2:0] ecnt, logic [1:0] eptr,
                              logic eovf, logic eudf);
    vec_t v;
    v.rst = rst; v.push = push; v.pop = pop; v.rest = rest;
    v.addr = addr; v.rptr = rptr; v.rcnt = rcnt;
    v.etop = etop; v.ecnt = ecnt; v.eptr = eptr; v.eovf = eovf; v.eudf = eudf;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; push_i = 1'b0; pop_i = 1'b0; restore_i = 1'b0;
    push_addr_i = '0; restore_ptr_i = '0; restore_cnt_i = '0;

    //                rst push pop rest addr         rptr rcnt  etop          cnt ptr ovf udf
    // basic push/pop
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0, 0,  FF,           0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h100,      0, 0,  32'h100,      1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h200,      0, 0,  32'h200,      2, 2, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h300,      0, 0,  32'h300,      3, 3, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0,        0, 0,  32'h200,      2, 2, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0,        0, 0,  32'h100,      1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0,        0, 0,  FF,           0, 0, 0, 0));
    // overflow then underflow
    vecs.push_back(mk(0, 1, 0, 0, 32'h10,       0, 0,  32'h10,       1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h20,       0, 0,  32'h20,       2, 2, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h30,       0, 0,  32'h30,       3, 3, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h40,       0, 0,  32'h40,       4, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h50,       0, 0,  32'h50,       4, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0,        0, 0,  32'h40,       3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0,        0, 0,  32'h30,       2, 3, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0,        0, 0,  32'h20,       1, 2, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0,        0, 0,  FF,           0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0,        0, 0,  FF,           0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0,  FF,           0, 1, 0, 0));
    // replace-top and push+pop on empty
    vecs.push_back(mk(0, 1, 0, 0, 32'hA0,       0, 0,  32'hA0,       1, 2, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'hB0,       0, 0,  32'hB0,       2, 3, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 32'hC0,       0, 0,  32'hC0,       2, 3, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0,        0, 0,  32'hA0,       1, 2, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0,        0, 0,  FF,           0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 32'hD0,       0, 0,  32'hD0,       1, 2, 0, 0));
    // checkpoint / restore with ignored push
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0, 0,  FF,           0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h1000,     0, 0,  32'h1000,     1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h2000,     0, 0,  32'h2000,     2, 2, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h3000,     0, 0,  32'h3000,     3, 3, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0,        0, 0,  32'h2000,     2, 2, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0,        0, 0,  32'h1000,     1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 32'h5000,     2, 2,  32'h2000,     2, 2, 0, 0));
    // restore count clamp
    vecs.push_back(mk(0, 0, 0, 1, 32'h0,        1, 7,  32'h1000,     4, 1, 0, 0));
    // wrap: six pushes into four entries
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0, 0,  FF,           0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h61,       0, 0,  32'h61,       1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h62,       0, 0,  32'h62,       2, 2, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h63,       0, 0,  32'h63,       3, 3, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h64,       0, 0,  32'h64,       4, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h65,       0, 0,  32'h65,       4, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h66,       0, 0,  32'h66,       4, 2, 1, 0));
    // reset beats push on a 3-entry stack, and beats pop on empty
    vecs.push_back(mk(0, 0, 1, 0, 32'h0,        0, 0,  32'h65,       3, 1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 32'h77,       0, 0,  FF,           0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0,  FF,           0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 32'h0,        0, 0,  FF,           0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0,  FF,           0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst; push_i = vecs[i].push; pop_i = vecs[i].pop;
      restore_i = vecs[i].rest; push_addr_i = vecs[i].addr;
      restore_ptr_i = vecs[i].rptr; restore_cnt_i = vecs[i].rcnt;
      @(posedge clk);
      #1;
      $display("vec %0d: rst=%0b push=%0b pop=%0b rest=%0b addr=0x%0h -> top=0x%0h cnt=%0d ptr=%0d ovf=%0b udf=%0b",
               i, vecs[i].rst, vecs[i].push, vecs[i].pop, vecs[i].rest, vecs[i].addr,
               top_addr_o, count_o, ckpt_ptr_o, overflow_o, underflow_o);
      chk($sformatf("vec%0d top", i),   top_addr_o, vecs[i].etop);
      chk($sformatf("vec%0d valid", i), 32'(top_valid_o), 32'(vecs[i].ecnt != 0));
      chk($sformatf("vec%0d count", i), 32'(count_o), 32'(vecs[i].ecnt));
      chk($sformatf("vec%0d ckcnt", i), 32'(ckpt_cnt_o), 32'(vecs[i].ecnt));
      chk($sformatf("vec%0d ptr", i),   32'(ckpt_ptr_o), 32'(vecs[i].eptr));
      chk($sformatf("vec%0d ovf", i),   32'(overflow_o), 32'(vecs[i].eovf));
      chk($sformatf("vec%0d udf", i),   32'(underflow_o), 32'(vecs[i].eudf));
    end

    // Inputs must not reach outputs before the edge; a push shows right after it.
    reset = 1'b0; restore_i = 1'b0; pop_i = 1'b0;
    push_i = 1'b1; push_addr_i = 32'hAAA0;
    #2;
    $display("seq pre-edge: push 0xAAA0 pending -> top=0x%0h cnt=%0d", top_addr_o, count_o);
    chk("pre_edge top", top_addr_o, FF);
    chk("pre_edge count", 32'(count_o), 32'd0);
    @(posedge clk);
    #1;
    push_i = 1'b0;
    $display("seq post-edge: -> top=0x%0h cnt=%0d", top_addr_o, count_o);
    chk("post_edge top", top_addr_o, 32'hAAA0);
    chk("post_edge count", 32'(count_o), 32'd1);
    push_addr_i = 32'hBBB0;
    @(posedge clk);
    #1;
    $display("seq hold: -> top=0x%0h cnt=%0d ptr=%0d", top_addr_o, count_o, ckpt_ptr_o);
    chk("hold top", top_addr_o, 32'hAAA0);
    chk("hold ptr", 32'(ckpt_ptr_o), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
